// File: rtl/lvg_pkg.sv
// rtl/lvg_pkg.sv - shared widths, FSM encoding and constants for the weight unloader
package lvg_pkg;

    localparam int LVG_DATA_W = 32;
    localparam int LVG_ADDR_W = 4;

    localparam logic [31:0] FP32_ONE = 32'h3f80_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } unl_state_e;

endpackage

// File: rtl/weight_unloader_if.sv
// rtl/weight_unloader_if.sv - control, memory read port and output stream of the weight unloader
interface weight_unloader_if
    import lvg_pkg::*;
#(
    parameter int DATA_W = LVG_DATA_W,
    parameter int ADDR_W = LVG_ADDR_W
) ();

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;

    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [ADDR_W:0]   out_index;

    modport master (
        input  start, base_addr, count, mem_rdata, out_ready,
        output busy, done, mem_re, mem_addr, out_valid, out_data, out_last, out_index
    );

    modport slave (
        output start, base_addr, count, mem_rdata, out_ready,
        input  busy, done, mem_re, mem_addr, out_valid, out_data, out_last, out_index
    );

endinterface

// File: rtl/weight_unloader_stream_fifo2.sv
// rtl/weight_unloader_stream_fifo2.sv - two-entry FIFO holding {last, index, data} stream beats
module stream_fifo2 #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign count_o = cnt_q;

endmodule

// File: rtl/weight_unloader.sv
// rtl/weight_unloader.sv - drains a contiguous block of weight memory onto a valid/ready stream
module weight_unloader
    import lvg_pkg::*;
#(
    parameter int DATA_W = LVG_DATA_W,
    parameter int ADDR_W = LVG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    weight_unloader_if.master bus
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int ENT_W = 1 + CNT_W + DATA_W;

    unl_state_e        state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  issued_q;
    logic              done_q;
    logic              pend_q;
    logic              pend_last_q;
    logic [CNT_W-1:0]  pend_idx_q;

    logic [ENT_W-1:0]  fifo_din;
    logic [ENT_W-1:0]  fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_cnt;

    logic              pop;
    logic              issue;
    logic              last_issue;
    logic [1:0]        slots_used;

    assign pop        = !fifo_empty && bus.out_ready;
    // A beat leaving this cycle frees a slot before the new read's data lands two edges later.
    assign slots_used = fifo_cnt + {1'b0, pend_q} - {1'b0, pop};
    assign last_issue = (issued_q == count_q - CNT_W'(1));
    assign issue      = (state_q == ST_STREAM) && (issued_q != count_q)
                        && (slots_used < 2'd2) && !(fifo_full && !pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            pend_idx_q  <= '0;
        end else begin
            done_q <= 1'b0;
            pend_q <= issue;
            if (issue) begin
                pend_idx_q  <= issued_q;
                pend_last_q <= last_issue;
                issued_q    <= issued_q + CNT_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q  <= ST_STREAM;
                            base_q   <= bus.base_addr;
                            count_q  <= bus.count;
                            issued_q <= '0;
                        end
                    end
                end
                ST_STREAM: begin
                    if (issue && last_issue) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && fifo_dout[ENT_W-1]) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fifo_din = {pend_last_q, pend_idx_q, bus.mem_rdata};

    stream_fifo2 #(
        .W (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pend_q),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.mem_re    = issue;
    assign bus.mem_addr  = base_q + issued_q[ADDR_W-1:0];
    assign bus.out_valid = !fifo_empty;
    assign bus.out_last  = fifo_dout[ENT_W-1];
    assign bus.out_index = fifo_dout[ENT_W-2 -: CNT_W];
    assign bus.out_data  = fifo_dout[DATA_W-1:0];

endmodule

// File: tb/tb_weight_unloader.sv
// tb/tb_weight_unloader.sv - scoreboard bench for the weight unloader
module tb_weight_unloader;
    import lvg_pkg::*;

    logic clk;
    logic rst;

    weight_unloader_if u_if ();

    weight_unloader dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [16];
    always @(posedge clk) if (u_if.mem_re) u_if.mem_rdata <= mem[u_if.mem_addr];

    int checks   = 0;
    int failures = 0;
    int beats    = 0;
    int outstanding = 0;
    logic [37:0] exp_q [$];
    logic [3:0]  addr_q [$];
    bit          stall_q = 1'b0;
    logic [37:0] held;

    always @(negedge clk) begin
        if (!rst) begin
            bit          hs;
            logic [37:0] cur;
            logic [37:0] e;
            logic [3:0]  ea;
            hs  = u_if.out_valid && u_if.out_ready;
            cur = {u_if.out_last, u_if.out_index, u_if.out_data};
            if (stall_q) begin
                checks++;
                if (u_if.out_valid !== 1'b1 || cur !== held) begin
                    failures++;
                    $display("FAIL stable_beat got valid=%b beat=%h expected valid=1 beat=%h", u_if.out_valid, cur, held);
                end
            end
            if (u_if.mem_re) begin
                checks++;
                if (outstanding - int'(hs) >= 2) begin
                    failures++;
                    $display("FAIL issue_rule got buffered+inflight=%0d expected <2", outstanding - int'(hs));
                end
                checks++;
                if (addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL read_addr got unexpected read at %0d expected no read", u_if.mem_addr);
                end else begin
                    ea = addr_q.pop_front();
                    if (u_if.mem_addr !== ea) begin
                        failures++;
                        $display("FAIL read_addr got %0d expected %0d", u_if.mem_addr, ea);
                    end
                end
            end
            if (hs) begin
                checks++;
                beats++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat got unexpected beat %h expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        failures++;
                        $display("FAIL beat got last/idx/data=%h expected %h", cur, e);
                    end
                end
            end
            outstanding = outstanding + int'(u_if.mem_re) - int'(hs);
            stall_q = u_if.out_valid && !u_if.out_ready;
            held    = cur;
        end
    end

    task automatic kick(input logic [3:0] b, input logic [4:0] n);
        @(posedge clk); #1;
        u_if.start = 1'b1;
        u_if.base_addr = b;
        u_if.count = n;
        for (int i = 0; i < int'(n); i++) begin
            logic [3:0] a;
            a = b + i[3:0];
            exp_q.push_back({(i == int'(n) - 1), i[4:0], mem[a]});
            addr_q.push_back(a);
        end
        @(posedge clk); #1;
        u_if.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            if (toggle) u_if.out_ready = (c % 3 == 0);
            if (u_if.done === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({u_if.busy, u_if.done, u_if.mem_re, u_if.out_valid, u_if.out_last} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got %b expected 00000", {u_if.busy, u_if.done, u_if.mem_re, u_if.out_valid, u_if.out_last});
        end
        checks++;
        if ({u_if.mem_addr, u_if.out_index, u_if.out_data} !== 41'b0) begin
            failures++;
            $display("FAIL reset_values got addr=%0d idx=%0d data=%h expected 0", u_if.mem_addr, u_if.out_index, u_if.out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_dump();
        int cyc;
        for (int i = 0; i < 16; i++) mem[i] = FP32_ONE;
        beats = 0;
        u_if.out_ready = 1'b1;
        kick(4'd0, 5'd16);
        checks++;
        if (u_if.mem_re !== 1'b1 || u_if.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL dump_e0 got re=%b valid=%b expected re=1 valid=0", u_if.mem_re, u_if.out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (u_if.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL dump_e1_valid got %b expected 0", u_if.out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (u_if.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL dump_e2_valid got %b expected 1", u_if.out_valid);
        end
        wait_done(40, 1'b0, cyc);
        checks++;
        if (cyc != 16 || u_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL dump_done_timing got cycle=%0d busy=%b expected cycle=16 busy=0", cyc, u_if.busy);
        end
        @(posedge clk); #1;
        checks++;
        if (u_if.done !== 1'b0) begin
            failures++;
            $display("FAIL dump_done_pulse got %b expected 0", u_if.done);
        end
        checks++;
        if (beats != 16 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL dump_count got beats=%0d left=%0d expected 16 and 0", beats, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        for (int i = 0; i < 16; i++) mem[i] = i;
        beats = 0;
        u_if.out_ready = 1'b1;
        kick(4'd0, 5'd8);
        wait_done(100, 1'b1, cyc);
        u_if.out_ready = 1'b1;
        checks++;
        if (cyc < 0 || beats != 8 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_count got cycle=%0d beats=%0d left=%0d expected done, 8 and 0", cyc, beats, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int cyc;
        for (int i = 0; i < 16; i++) mem[i] = 32'hc0de_0000 | i;
        beats = 0;
        u_if.out_ready = 1'b1;
        kick(4'd14, 5'd4);
        wait_done(30, 1'b0, cyc);
        checks++;
        if (cyc < 0 || beats != 4 || exp_q.size() != 0 || addr_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_count got cycle=%0d beats=%0d left=%0d/%0d expected done, 4, 0/0", cyc, beats, exp_q.size(), addr_q.size());
        end
    endtask

    task automatic test_zero_and_busy();
        int cyc;
        beats = 0;
        u_if.out_ready = 1'b1;
        kick(4'd5, 5'd0);
        checks++;
        if (u_if.done !== 1'b1 || u_if.out_valid !== 1'b0 || u_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_done got done=%b valid=%b busy=%b expected 1 0 0", u_if.done, u_if.out_valid, u_if.busy);
        end
        @(posedge clk); #1;
        checks++;
        if (u_if.done !== 1'b0 || u_if.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_after got done=%b valid=%b expected 0 0", u_if.done, u_if.out_valid);
        end
        kick(4'd2, 5'd3);
        u_if.start = 1'b1;
        u_if.base_addr = 4'd9;
        u_if.count = 5'd5;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        wait_done(30, 1'b0, cyc);
        checks++;
        if (cyc < 0 || beats != 3 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL busy_start got cycle=%0d beats=%0d left=%0d expected done, 3 and 0", cyc, beats, exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (u_if.busy !== 1'b0 || u_if.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_idle got busy=%b valid=%b expected 0 0", u_if.busy, u_if.out_valid);
        end
    endtask

    task automatic test_reset_mid_stream();
        int cyc;
        for (int i = 0; i < 16; i++) mem[i] = 32'ha000_0000 | i;
        beats = 0;
        u_if.out_ready = 1'b1;
        kick(4'd0, 5'd16);
        for (int c = 0; c < 50 && beats < 5; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (beats < 5) begin
            failures++;
            $display("FAIL mid_reach got beats=%0d expected 5", beats);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({u_if.busy, u_if.done, u_if.mem_re, u_if.out_valid, u_if.out_last} !== 5'b0) begin
            failures++;
            $display("FAIL mid_reset_flags got %b expected 00000", {u_if.busy, u_if.done, u_if.mem_re, u_if.out_valid, u_if.out_last});
        end
        checks++;
        if ({u_if.mem_addr, u_if.out_index, u_if.out_data} !== 41'b0) begin
            failures++;
            $display("FAIL mid_reset_values got addr=%0d idx=%0d data=%h expected 0", u_if.mem_addr, u_if.out_index, u_if.out_data);
        end
        exp_q.delete();
        addr_q.delete();
        outstanding = 0;
        stall_q = 1'b0;
        beats = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem[0] = 32'h1111_0000;
        mem[1] = 32'h2222_0001;
        kick(4'd0, 5'd2);
        wait_done(20, 1'b0, cyc);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cyc < 0 || beats != 2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL mid_restart got cycle=%0d beats=%0d left=%0d expected done, 2 and 0", cyc, beats, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        u_if.start = 1'b0;
        u_if.base_addr = '0;
        u_if.count = '0;
        u_if.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_wrap();
        test_zero_and_busy();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/weight_unloader.md
Name: weight_unloader

Overview:
- Reads a contiguous block of fp32 words out of the head's weight memory through its synchronous read port and streams them to the host over a valid/ready interface.
- It is the read-back counterpart of the weight loader: the loader fills weightMem, and this block drains results such as a 4x4 matrix after a program runs.
- Sits between the head's weight memory read port and the host/debug link.

Parameters:
- DATA_W, 32, word width (fp32)
- ADDR_W, 4, weight memory address width (16 words)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a transfer
- base_addr  in  ADDR_W  first word address, sampled with start
- count  in  ADDR_W+1  number of words (0..2^ADDR_W), sampled with start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after the last beat is accepted
- mem_re  out  1  weight memory read enable
- mem_addr  out  ADDR_W  weight memory read address
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_re
- out_valid  out  1  stream beat valid
- out_ready  in  1  host accepts beat
- out_data  out  DATA_W  stream word
- out_last  out  1  final beat of the transfer
- out_index  out  ADDR_W+1  beat number, 0-based

Behaviour:
- Reset (async, any time, including mid-transfer): state IDLE; busy, done, mem_re, out_valid, out_last = 0; mem_addr, out_data, out_index = 0; buffer flushed; in-flight read discarded.
- States:
  - IDLE: start=1 with count>0 → STREAM, latching base_addr/count and clearing the counters. start=1 with count=0 → done pulses in the next cycle and the block stays IDLE with no beats.
  - STREAM: issues reads until count reads are issued → DRAIN.
  - DRAIN: waits until the buffer is empty and the last beat is accepted → IDLE, done=1 for one cycle.
- busy=1 in STREAM and DRAIN. start is ignored while busy.
- Read issue: mem_re=1 only when (buffer occupancy + in-flight read) < 2. mem_addr = (base + issued) mod 2^ADDR_W, so addresses wrap from 2^ADDR_W-1 to 0.
- Read data is captured into a 2-entry FIFO on the cycle after mem_re. It is never dropped: the issue rule guarantees space.
- Output:
  - out_data/out_last/out_index come from the FIFO head; out_valid = FIFO non-empty.
  - A beat transfers when out_valid and out_ready are both 1. Once out_valid is asserted, data stays stable until accepted.
  - out_last=1 only on beat index count-1.
- Latency: start sampled at edge E0; mem_re high E0–E1; data in FIFO at E2; out_valid high after E2.
- Throughput: 1 beat/cycle with out_ready held high. Under backpressure, at most 2 words are buffered and no reads are lost or duplicated.
- Simultaneous FIFO push and pop in the same cycle is legal and keeps occupancy unchanged.
- done rises the cycle after the last handshake, and busy falls in that same cycle.
- Counters are ADDR_W+1 bits so that count = 2^ADDR_W (full memory) is legal.

Decomposition:
- Shared package lvg_pkg holds:
  - DATA_W/ADDR_W defaults
  - state encoding (IDLE, STREAM, DRAIN)
  - the FP32_ONE constant 32'h3f800000 used by benches
- Sub-module stream_fifo2: a 2-entry FIFO holding {last, index, data}, with push/pop/full/empty/count outputs. This is the natural split; the FSM and read-issue logic stay in weight_unloader.

Test Plan:
- Full dump at max throughput:
  - Stimulus: memory preloaded with 16×32'h3f800000, base 0, count 16, out_ready=1.
  - Required response: 16 consecutive beats of 3f800000 with index 0..15; first out_valid 2 cycles after start; out_last only on index 15; done one cycle after the final handshake.
- Backpressure:
  - Stimulus: mem[i]=i, count 8, out_ready toggling 1,0,0,1,...
  - Required response: data 0..7 in order with none repeated or dropped; mem_re never issued when the FIFO plus in-flight count is 2; out_data stable while out_valid=1 and out_ready=0.
- Wrap-around:
  - Stimulus: base 14, count 4.
  - Required response: reads at addresses 14,15,0,1; out_data = mem[14],mem[15],mem[0],mem[1]; last on index 3.
- Zero count and start while busy:
  - Stimulus: count 0, then start=1 again mid-transfer of count 3.
  - Required response: the first start gives done the next cycle with no out_valid; the second start is ignored and exactly 3 beats are sent.
- Reset mid-stream:
  - Stimulus: assert rst asynchronously after beat 5 of 16.
  - Required response: all outputs go to 0 immediately. A new start with base 0, count 2 then yields exactly 2 beats, mem[0] and mem[1], with no stale data.
